// File: rtl/multicycle_adder_pkg.sv
// Shared definitions for the multi-cycle adder: FSM state encoding and
// the helpers that derive chunk count and chunk-index width from the parameters.
package multicycle_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk adder still needs a one-bit index register.
    function automatic int calc_idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/multicycle_adder_chunk_adder.sv
// Combinational CHUNK-bit adder with carry in and carry out.
// The multi-cycle adder reuses one instance of it for every chunk.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/multicycle_adder.sv
// Multi-cycle add/subtract unit: adds CHUNK bits per cycle using a single
// chunk adder, with valid/ready handshakes on both the operand and result sides.
module multicycle_adder
    import multicycle_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = calc_idx_w(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry;
    logic             c_out_reg;
    logic [IDX_W-1:0] idx;

    int               bit_pos;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_cout;

    assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
    assign out_valid = (state == HOLD);
    assign busy      = (state == ADD);
    assign sum       = sum_reg;
    assign c_out     = c_out_reg;

    always_comb begin
        bit_pos = int'(idx) * CHUNK;
        chunk_a = a_reg[bit_pos +: CHUNK];
        chunk_b = b_reg[bit_pos +: CHUNK];
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry),
        .s    (chunk_s),
        .cout (chunk_cout)
    );

    // Subtraction is folded into addition at load time: b is inverted and the
    // borrow-in becomes an inverted carry-in, so ADD never needs to know op.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry     <= 1'b0;
            c_out_reg <= 1'b0;
            idx       <= '0;
        end else if (in_valid && in_ready) begin
            a_reg <= a;
            b_reg <= op ? ~b : b;
            carry <= op ? ~c_in : c_in;
            idx   <= '0;
            state <= ADD;
        end else if (state == ADD) begin
            sum_reg[bit_pos +: CHUNK] <= chunk_s;
            carry                     <= chunk_cout;
            if (idx == LAST_IDX) begin
                c_out_reg <= chunk_cout;
                idx       <= '0;
                state     <= HOLD;
            end else begin
                idx <= idx + 1'b1;
            end
        end else if ((state == HOLD) && out_ready) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_multicycle_adder.sv
// Self-checking bench for multicycle_adder: directed vector table on the default
// 16/4 build, handshake and reset corner cases, and a random sweep over CHUNK 1/4/16.
module tb_multicycle_adder;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        op;
    logic        out_ready;

    logic        in_ready_c1, in_ready_c4, in_ready_c16;
    logic        out_valid_c1, out_valid_c4, out_valid_c16;
    logic [15:0] sum_c1, sum_c4, sum_c16;
    logic        c_out_c1, c_out_c4, c_out_c16;
    logic        busy_c1, busy_c4, busy_c16;

    int pass_count  = 0;
    int check_count = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c_in;
        logic        op;
        logic [15:0] exp_sum;
        logic        exp_c_out;
    } vector_t;

    vector_t vectors[8];

    multicycle_adder #(.WIDTH(16), .CHUNK(1)) dut_c1 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_c1),
        .a(a), .b(b), .c_in(c_in), .op(op), .out_valid(out_valid_c1),
        .out_ready(out_ready), .sum(sum_c1), .c_out(c_out_c1), .busy(busy_c1)
    );

    multicycle_adder #(.WIDTH(16), .CHUNK(4)) dut_c4 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_c4),
        .a(a), .b(b), .c_in(c_in), .op(op), .out_valid(out_valid_c4),
        .out_ready(out_ready), .sum(sum_c4), .c_out(c_out_c4), .busy(busy_c4)
    );

    multicycle_adder #(.WIDTH(16), .CHUNK(16)) dut_c16 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_c16),
        .a(a), .b(b), .c_in(c_in), .op(op), .out_valid(out_valid_c16),
        .out_ready(out_ready), .sum(sum_c16), .c_out(c_out_c16), .busy(busy_c16)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Hands one operand set to all three builds and returns each build's latency
    // (edges after acceptance until out_valid), or -1 if it never arrived.
    task automatic applyStimulus(input logic [15:0] op_a, input logic [15:0] op_b,
                                 input logic op_c_in, input logic op_sub,
                                 output int lat_c1, output int lat_c4, output int lat_c16);
        int cycles;
        lat_c1  = -1;
        lat_c4  = -1;
        lat_c16 = -1;
        @(posedge clock);
        #1;
        a        = op_a;
        b        = op_b;
        c_in     = op_c_in;
        op       = op_sub;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        cycles   = 0;
        while ((lat_c1 < 0 || lat_c4 < 0 || lat_c16 < 0) && cycles < 40) begin
            @(posedge clock);
            #1;
            cycles++;
            if (lat_c1 < 0 && out_valid_c1)   lat_c1  = cycles;
            if (lat_c4 < 0 && out_valid_c4)   lat_c4  = cycles;
            if (lat_c16 < 0 && out_valid_c16) lat_c16 = cycles;
        end
        if (cycles >= 40) checkOutput("result_timeout", 32'(cycles), 32'd0);
    endtask

    task automatic releaseResult();
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat1, lat4, lat16;
        int cycles;
        logic seen_valid;
        logic [16:0] ref_val;
        logic [15:0] ra, rb;
        logic rc, rop;

        vectors[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0};
        vectors[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1};
        vectors[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0};
        vectors[3] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1};
        vectors[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0};
        vectors[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1};
        vectors[6] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0};
        vectors[7] = '{16'hABCD, 16'h1234, 1'b0, 1'b1, 16'h9999, 1'b1};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        op        = 1'b0;
        out_ready = 1'b0;
        #12;
        checkOutput("reset_out_valid", 32'(out_valid_c4), 32'd0);
        checkOutput("reset_busy", 32'(busy_c4), 32'd0);
        checkOutput("reset_sum", 32'(sum_c4), 32'd0);
        checkOutput("reset_c_out", 32'(c_out_c4), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready_c4), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;

        $display("[TB] directed vector table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vectors[i].a, vectors[i].b, vectors[i].c_in, vectors[i].op,
                          lat1, lat4, lat16);
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat4), 32'd4);
            checkOutput($sformatf("vec%0d_sum", i), 32'(sum_c4), 32'(vectors[i].exp_sum));
            checkOutput($sformatf("vec%0d_c_out", i), 32'(c_out_c4), 32'(vectors[i].exp_c_out));
            releaseResult();
        end

        $display("[TB] back-pressure then back-to-back");
        applyStimulus(16'h0100, 16'h0023, 1'b0, 1'b0, lat1, lat4, lat16);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            checkOutput($sformatf("stall%0d_sum", i), 32'(sum_c4), 32'h0123);
            checkOutput($sformatf("stall%0d_in_ready", i), 32'(in_ready_c4), 32'd0);
            checkOutput($sformatf("stall%0d_out_valid", i), 32'(out_valid_c4), 32'd1);
        end
        a         = 16'h0010;
        b         = 16'h0020;
        c_in      = 1'b0;
        op        = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        checkOutput("b2b_busy", 32'(busy_c4), 32'd1);
        checkOutput("b2b_out_valid", 32'(out_valid_c4), 32'd0);
        // Operands changed while ADD runs must not disturb the accepted ones.
        a = 16'hFFFF;
        b = 16'hFFFF;
        cycles = 0;
        while (!out_valid_c4 && cycles < 20) begin
            @(posedge clock);
            #1;
            cycles++;
        end
        in_valid = 1'b0;
        checkOutput("b2b_latency", 32'(cycles), 32'd4);
        checkOutput("b2b_sum", 32'(sum_c4), 32'h0030);
        checkOutput("b2b_c_out", 32'(c_out_c4), 32'd0);
        releaseResult();
        checkOutput("idle_sum_held", 32'(sum_c4), 32'h0030);
        checkOutput("idle_in_ready", 32'(in_ready_c4), 32'd1);

        $display("[TB] reset during ADD");
        @(posedge clock);
        #1;
        a        = 16'h1111;
        b        = 16'h1111;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("mid_add_busy", 32'(busy_c4), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_reset_sum", 32'(sum_c4), 32'd0);
        checkOutput("mid_reset_c_out", 32'(c_out_c4), 32'd0);
        checkOutput("mid_reset_out_valid", 32'(out_valid_c4), 32'd0);
        checkOutput("mid_reset_busy", 32'(busy_c4), 32'd0);
        checkOutput("mid_reset_in_ready", 32'(in_ready_c4), 32'd1);
        @(negedge clock);
        reset_n    = 1'b1;
        seen_valid = 1'b0;
        repeat (8) begin
            @(posedge clock);
            #1;
            if (out_valid_c4 || out_valid_c1 || out_valid_c16) seen_valid = 1'b1;
        end
        checkOutput("mid_reset_no_result", 32'(seen_valid), 32'd0);
        checkOutput("mid_reset_idle_ready", 32'(in_ready_c4), 32'd1);

        $display("[TB] random sweep over CHUNK 1/4/16");
        for (int i = 0; i < 1000; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rc  = 1'($urandom_range(1));
            rop = 1'($urandom_range(1));
            if (rop)
                ref_val = {1'b0, ra} + {1'b0, ~rb} + 17'(!rc);
            else
                ref_val = {1'b0, ra} + {1'b0, rb} + 17'(rc);
            applyStimulus(ra, rb, rc, rop, lat1, lat4, lat16);
            checkOutput("sweep_c1_result", 32'({c_out_c1, sum_c1}), 32'(ref_val));
            checkOutput("sweep_c4_result", 32'({c_out_c4, sum_c4}), 32'(ref_val));
            checkOutput("sweep_c16_result", 32'({c_out_c16, sum_c16}), 32'(ref_val));
            checkOutput("sweep_c1_latency", 32'(lat1), 32'd16);
            checkOutput("sweep_c4_latency", 32'(lat4), 32'd4);
            checkOutput("sweep_c16_latency", 32'(lat16), 32'd1);
            releaseResult();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
